// File: rtl/bin_frame_capture_ctrl.sv
// One-shot binarised frame capture sequencer: arm on HPS start, pack pixels into words, pace HPS readout.
// Optional FRAME_CHECKSUM_EN adds an XOR checksum of written words and a readback compare (oSTATE bit 7).
module bin_frame_capture_ctrl #(
    parameter int          SHIFT_WIDTH = 16,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [23:0] TIMEOUT_CYC = 24'd16777215
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iSTART,
    input  logic                   iFVAL,
    input  logic                   iPIX,
    input  logic                   iPIX_VAL,
    input  logic                   iHPS_CLK,
    output logic                   oCAP_EN,
    output logic [SHIFT_WIDTH-1:0] oWR_DATA,
    output logic                   oWR_EN,
    output logic                   oWR_LOAD,
    output logic                   oRD_EN,
    output logic                   oRD_LOAD,
    output logic [14:0]            oWORD_CNT,
    output logic                   oDONE,
    output logic [9:0]             oSTATE
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [SHIFT_WIDTH-1:0] oCHECKSUM,
    input  logic [SHIFT_WIDTH-1:0] iRD_DATA
`endif
);

    localparam int               WORDS    = H_ACTIVE * V_ACTIVE / SHIFT_WIDTH;
    localparam int               BW       = $clog2(SHIFT_WIDTH);
    localparam logic [14:0]      WORDS_M1 = 15'(WORDS - 1);
    localparam logic [BW-1:0]    LAST_BIT = BW'(SHIFT_WIDTH - 1);

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_ARM     = 7'b0000010,
        S_CAPTURE = 7'b0000100,
        S_FLUSH   = 7'b0001000,
        S_READOUT = 7'b0010000,
        S_DONE    = 7'b0100000,
        S_ABORT   = 7'b1000000
    } state_t;

    state_t                 state;
    logic                   start_q;
    logic                   fval_q;
    logic [SHIFT_WIDTH-2:0] pack;
    logic [BW-1:0]          bit_cnt;
    logic [23:0]            timer;
    logic [2:0]             flush_cnt;
    logic                   hps_s1, hps_s2, hps_s3;

    logic                   start_rise, fval_rise, fval_fall, hps_rise, pix_last, timeout;
    logic [23:0]            timer_nxt;
    logic [SHIFT_WIDTH-1:0] word;

    assign start_rise = iSTART & ~start_q;
    assign fval_rise  = iFVAL & ~fval_q;
    assign fval_fall  = ~iFVAL & fval_q;
    assign hps_rise   = hps_s2 & ~hps_s3;
    assign pix_last   = iPIX_VAL && (bit_cnt == LAST_BIT);
    // The completing pixel goes straight into the top bit of the outgoing word.
    assign word       = {iPIX, pack};
    assign timer_nxt  = (timer == 24'hFFFFFF) ? timer : timer + 24'd1;
    assign timeout    = (timer_nxt == TIMEOUT_CYC);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            fval_q    <= 1'b0;
            pack      <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
            flush_cnt <= '0;
            hps_s1    <= 1'b0;
            hps_s2    <= 1'b0;
            hps_s3    <= 1'b0;
            oCAP_EN   <= 1'b0;
            oWR_DATA  <= '0;
            oWR_EN    <= 1'b0;
            oWR_LOAD  <= 1'b0;
            oRD_EN    <= 1'b0;
            oRD_LOAD  <= 1'b0;
            oWORD_CNT <= '0;
            oDONE     <= 1'b0;
        end else begin
            start_q  <= iSTART;
            fval_q   <= iFVAL;
            hps_s1   <= iHPS_CLK;
            hps_s2   <= hps_s1;
            hps_s3   <= hps_s2;
            oWR_EN   <= 1'b0;
            oWR_LOAD <= 1'b0;
            oRD_EN   <= 1'b0;
            oRD_LOAD <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        oWR_LOAD  <= 1'b1;
                        oRD_LOAD  <= 1'b1;
                        oWORD_CNT <= '0;
                        oDONE     <= 1'b0;
                        pack      <= '0;
                        bit_cnt   <= '0;
                        timer     <= '0;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    timer <= timer_nxt;
                    if (timeout) begin
                        state <= S_ABORT;
                    end else if (fval_rise) begin
                        oCAP_EN <= 1'b1;
                        state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    timer <= timer_nxt;
                    if (iPIX_VAL) begin
                        if (!pix_last)
                            pack[bit_cnt] <= iPIX;
                        bit_cnt <= pix_last ? '0 : bit_cnt + 1'b1;
                    end
                    if (pix_last) begin
                        oWR_DATA  <= word;
                        oWR_EN    <= 1'b1;
                        oWORD_CNT <= oWORD_CNT + 15'd1;
                    end
                    // A completing word is always written, even when the frame ends or times out with it.
                    if (pix_last && oWORD_CNT == WORDS_M1) begin
                        oCAP_EN   <= 1'b0;
                        flush_cnt <= '0;
                        state     <= S_FLUSH;
                    end else if (fval_fall || timeout) begin
                        oCAP_EN <= 1'b0;
                        state   <= S_ABORT;
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt + 3'd1;
                    if (flush_cnt == 3'd7) begin
                        oWORD_CNT <= '0;
                        state     <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (hps_rise) begin
                        oRD_EN    <= 1'b1;
                        oWORD_CNT <= oWORD_CNT + 15'd1;
                        if (oWORD_CNT == WORDS_M1) begin
                            oDONE <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!iSTART) begin
                        oDONE <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ABORT: begin
                    if (!iSTART)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [SHIFT_WIDTH-1:0] csum, rd_xor;
    logic                   rd_en_q, csum_err;

    // Read data arrives the cycle after oRD_EN; the final compare fires on the last read's data.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            csum     <= '0;
            rd_xor   <= '0;
            rd_en_q  <= 1'b0;
            csum_err <= 1'b0;
        end else begin
            rd_en_q <= oRD_EN;
            if (state == S_IDLE && start_rise) begin
                csum     <= '0;
                rd_xor   <= '0;
                csum_err <= 1'b0;
            end else begin
                if (state == S_CAPTURE && pix_last)
                    csum <= csum ^ word;
                if (rd_en_q)
                    rd_xor <= rd_xor ^ iRD_DATA;
                if (rd_en_q && oWORD_CNT == 15'(WORDS))
                    csum_err <= ((rd_xor ^ iRD_DATA) != csum);
            end
        end
    end

    assign oCHECKSUM = csum;
    assign oSTATE    = {2'b00, csum_err, state};
`else
    assign oSTATE    = {3'b000, state};
`endif

endmodule

// File: doc/bin_frame_capture_ctrl.md
Name: bin_frame_capture_ctrl

Overview:
- Sequences one-shot capture of a binarised 640x480 frame for HPS processing.
- Arms on an HPS start request and aligns to a frame boundary (FVAL low-to-high).
- Packs 1-bit pixels into SHIFT_WIDTH-bit words for the SDRAM write FIFO and counts words to frame completion.
- Then paces HPS readout: one packed word per HPS software-clock rising edge, with a done flag and state code for LEDR.

Parameters:
- SHIFT_WIDTH, 16: pixels per packed word; must divide H_ACTIVE.
- H_ACTIVE, 640: valid pixels per line.
- V_ACTIVE, 480: lines per frame.
- TIMEOUT_CYC, 24'd16777215: iCLK cycles allowed in ARM/CAPTURE before abort.

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge.
- iRST  in  1  synchronous active-high reset.
- iSTART  in  1  HPS capture request, level; rising edge (registered) starts a capture.
- iFVAL  in  1  registered frame-valid from sensor.
- iPIX  in  1  binarised pixel.
- iPIX_VAL  in  1  pixel valid qualifier.
- iHPS_CLK  in  1  HPS-toggled read strobe, asynchronous; synchronised internally.
- oCAP_EN  out  1  capture enable to CCD capture block.
- oWR_DATA  out  SHIFT_WIDTH  packed word; bit 0 = earliest pixel.
- oWR_EN  out  1  one-cycle write strobe for oWR_DATA.
- oWR_LOAD  out  1  one-cycle FIFO address reload pulse.
- oRD_EN  out  1  one-cycle read-advance pulse to read FIFO.
- oRD_LOAD  out  1  one-cycle read address reload pulse.
- oWORD_CNT  out  15  words written (CAPTURE) or words read (READOUT).
- oDONE  out  1  readout complete.
- oSTATE  out  10  one-hot state code for LEDR.

Behaviour:
- Reset: every output 0 except oSTATE = 10'b0000000001 (IDLE). Pack register, bit counter, timer and synchronisers are cleared.
- WORDS = H_ACTIVE*V_ACTIVE/SHIFT_WIDTH (19200 at defaults).
- States (one-hot bit index): IDLE0, ARM1, CAPTURE2, FLUSH3, READOUT4, DONE5, ABORT6; bits 9:7 are always 0.
- IDLE: on an iSTART rising edge, pulse oWR_LOAD and oRD_LOAD for 1 cycle, clear counters, go to ARM.
- ARM:
  - Wait for iFVAL low then high.
  - The cycle the rising edge is seen, go to CAPTURE with oCAP_EN=1.
  - A capture never starts mid-frame.
- CAPTURE:
  - Each cycle with iPIX_VAL=1, shift iPIX into the pack register at index bit_cnt.
  - On the SHIFT_WIDTH-th pixel: next cycle oWR_DATA = word, oWR_EN=1 for exactly 1 cycle, oWORD_CNT+1. Write latency is 1 cycle after the completing pixel.
  - iPIX_VAL=0 holds the pack state.
  - iFVAL falling before WORDS written: go to ABORT.
  - oWORD_CNT reaching WORDS: oCAP_EN=0, go to FLUSH. Pixels after the last word are ignored.
- FLUSH: wait 8 cycles for FIFO drain, clear oWORD_CNT, go to READOUT.
- READOUT:
  - iHPS_CLK passes through a 2-flop synchroniser plus an edge register.
  - Each synchronised rising edge: oRD_EN=1 for 1 cycle, oWORD_CNT+1. Falling edges are ignored.
  - Edge detection latency is 3 iCLK cycles.
  - After WORDS reads, go to DONE.
- DONE: oDONE=1. Stay until iSTART is low, then return to IDLE. A new iSTART rising edge is only accepted from IDLE.
- ABORT: oCAP_EN=0, oSTATE bit6=1. On iSTART low, return to IDLE.
- Timeout: the timer runs in ARM and CAPTURE. When the timer reaches TIMEOUT_CYC, go to ABORT.
- Simultaneous events:
  - Word completion and iFVAL fall in the same cycle: the word write still occurs, then ABORT.
  - iSTART dropped mid-capture: ignored.
- Counters saturate; no wrap-around in oWORD_CNT.
- iRST mid-operation returns to IDLE next edge, with no write/read pulse issued that cycle.

Optional Feature:
- FRAME_CHECKSUM_EN.
- Defined:
  - Adds output oCHECKSUM[SHIFT_WIDTH-1:0].
  - XOR of all words written in the current capture, cleared on entry to ARM.
  - Valid and held from FLUSH until the next ARM.
  - READOUT additionally compares the XOR of read words (from new input iRD_DATA[SHIFT_WIDTH-1:0], sampled 1 cycle after oRD_EN). A mismatch at DONE sets oSTATE bit7.
- Undefined: neither the ports nor the logic exist; bit7 is tied 0.

Test Plan:
- Reset: assert iRST 3 cycles -> oSTATE=0x001, all other outputs 0; oWR_EN never pulses.
- Mid-frame arm: iSTART rises while iFVAL=1 -> no oCAP_EN until iFVAL falls and rises again, then oCAP_EN=1 on that edge cycle.
- Packing: 16 valid pixels 1,0,0,...,0,1 -> one oWR_EN pulse 1 cycle after the 16th pixel, oWR_DATA=0x8001, oWORD_CNT=1. Gaps in iPIX_VAL do not change the result.
- Full frame: 307200 valid pixels in one frame -> exactly 19200 oWR_EN pulses, then FLUSH 8 cycles, then READOUT with oWORD_CNT=0.
- Readout: 19200 iHPS_CLK toggles (period 20 iCLK) -> 19200 oRD_EN pulses, each 3 cycles after a rising edge; oDONE=1; iSTART low -> IDLE.
- Abort: iFVAL falls after 100 words -> ABORT (oSTATE=0x040), oCAP_EN=0, no further writes. A TIMEOUT_CYC=1000 variant reaches ABORT at cycle 1000 of ARM.
